// File: rtl/pattern_scan_pkg.sv
// Shared encodings for the "101" scan controller and its Moore detector.
// Optional build macro: PSCAN_MSB_FIRST_EN (serialise MSB first).
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3
    } det_state_t;

endpackage

// File: rtl/pattern_scan_ctrl_seq101.sv
// Moore recogniser for overlapping "101"; Y is high only in S3.
// clr wins over en so a new job always starts from S0.
module seq101_moore
    import pattern_scan_pkg::*;
(
    input  logic clk,
    input  logic r,
    input  logic clr,
    input  logic en,
    input  logic X,
    output logic Y
);

    det_state_t state;
    det_state_t state_nx;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state <= S0;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = S0;
        end else if (en) begin
            case (state)
                S0:      state_nx = X ? S1 : S0;
                S1:      state_nx = X ? S1 : S2;
                S2:      state_nx = X ? S3 : S0;
                S3:      state_nx = X ? S1 : S2;
                default: state_nx = S0;
            endcase
        end
    end

    assign Y = (state == S3);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Loads a word, streams it into the "101" detector and counts hits.
// Optional build macro: PSCAN_MSB_FIRST_EN (MSB first; default LSB first).
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic [W-1:0]     din,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits,
    output logic             x_out,
    output logic             y_mon
);

    localparam int BC_W = $clog2(W);
    localparam logic [BC_W-1:0] LAST = BC_W'(W - 1);
    localparam logic [CNT_W-1:0] HMAX = '1;

    ctrl_state_t state;
    ctrl_state_t state_nx;

    logic [W-1:0]    shreg;
    logic [W-1:0]    shreg_nx;
    logic [BC_W-1:0] bitcnt;
    logic            accept;
    logic            det_clr;
    logic            det_en;
    logic            x_bit;

`ifdef PSCAN_MSB_FIRST_EN
    assign x_bit    = shreg[W-1];
    assign shreg_nx = {shreg[W-2:0], 1'b0};
`else
    assign x_bit    = shreg[0];
    assign shreg_nx = {1'b0, shreg[W-1:1]};
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        det_clr  = 1'b0;
        det_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SHIFT;
                    accept   = 1'b1;
                    det_clr  = 1'b1;
                end
            end
            SHIFT: begin
                det_en = 1'b1;
                if (bitcnt == LAST) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // DRAIN still counts: it shows the match closed by the last bit.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            hits   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                shreg  <= din;
                bitcnt <= '0;
                hits   <= '0;
            end else begin
                if (state == SHIFT) begin
                    shreg  <= shreg_nx;
                    bitcnt <= bitcnt + 1'b1;
                end
                if (busy && y_mon && hits != HMAX) begin
                    hits <= hits + 1'b1;
                end
            end
        end
    end

    assign busy  = (state == SHIFT) || (state == DRAIN);
    assign done  = (state == DONE);
    assign x_out = (state == SHIFT) && x_bit;

    seq101_moore u_det (
        .clk (clk),
        .r   (r),
        .clr (det_clr),
        .en  (det_en),
        .X   (x_out),
        .Y   (y_mon)
    );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Randomised self-checking bench for pattern_scan_ctrl (W=8 and a W=16/CNT_W=2 instance).
// Bit order follows PSCAN_MSB_FIRST_EN when the bench is built with it.
module tb_pattern_scan_ctrl;

    logic        clk = 1'b0;
    logic        r;
    logic        start;
    logic [7:0]  din;
    logic        busy;
    logic        done;
    logic [3:0]  hits;
    logic        x_out;
    logic        y_mon;

    logic        start2;
    logic [15:0] din2;
    logic        busy2;
    logic        done2;
    logic [1:0]  hits2;
    logic        x2;
    logic        y2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(.W(8), .CNT_W(4)) dut (
        .clk   (clk),
        .r     (r),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .hits  (hits),
        .x_out (x_out),
        .y_mon (y_mon)
    );

    pattern_scan_ctrl #(.W(16), .CNT_W(2)) u_sat (
        .clk   (clk),
        .r     (r),
        .start (start2),
        .din   (din2),
        .busy  (busy2),
        .done  (done2),
        .hits  (hits2),
        .x_out (x2),
        .y_mon (y2)
    );

    function automatic logic bit_at(input logic [15:0] v, input int n, input int i);
`ifdef PSCAN_MSB_FIRST_EN
        return v[n-1-i];
`else
        return v[i];
`endif
    endfunction

    function automatic int count101(input logic [15:0] v, input int n);
        int c = 0;
        for (int i = 0; i + 2 < n; i++) begin
            if (bit_at(v, n, i) && !bit_at(v, n, i+1) && bit_at(v, n, i+2)) c++;
        end
        return c;
    endfunction

    task automatic launch(input logic [7:0] d);
        @(negedge clk);
        din   = d;
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called one tick after the accept edge; cycle k lies between edges k and k+1.
    task automatic observe(input logic [7:0] d, input int inject_at,
                           input bit hold, input string tag);
        logic [8:0]  xo, xe, yo, ye;
        logic [10:0] bo, be, dn, de;
        logic [3:0]  he, h0, h9, h10;
        logic        b11, d11;
        int c;
        c  = count101({8'h00, d}, 8);
        he = (c > 15) ? 4'hF : 4'(c);
        xe = '0; ye = '0; be = '0; de = '0;
        xo = '0; yo = '0; bo = '0; dn = '0;
        h0 = '0; h9 = '0; h10 = '0; b11 = 1'b0; d11 = 1'b0;
        for (int k = 0; k < 8; k++) xe[k] = bit_at({8'h00, d}, 8, k);
        for (int k = 3; k <= 8; k++)
            ye[k] = bit_at({8'h00, d}, 8, k-3) & !bit_at({8'h00, d}, 8, k-2)
                  & bit_at({8'h00, d}, 8, k-1);
        for (int k = 0; k <= 8; k++) be[k] = 1'b1;
        de[9] = 1'b1;
        if (!hold) start = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 8) begin xo[k] = x_out; yo[k] = y_mon; end
            if (k <= 10) begin bo[k] = busy; dn[k] = done; end
            if (k == 0) h0 = hits;
            if (k == 9) h9 = hits;
            if (k == 10) h10 = hits;
            if (k == 11) begin b11 = busy; d11 = done; end
            if (k == inject_at) begin
                start = 1'b1;
                din   = 8'h55;
            end else if (k == inject_at + 1) begin
                start = hold;
            end
        end
        tests += 8;
        if (xo !== xe) begin fails++; $display("FAIL %s x_out got %b want %b", tag, xo, xe); end
        if (yo !== ye) begin fails++; $display("FAIL %s y_mon got %b want %b", tag, yo, ye); end
        if (bo !== be) begin fails++; $display("FAIL %s busy got %b want %b", tag, bo, be); end
        if (dn !== de) begin fails++; $display("FAIL %s done got %b want %b", tag, dn, de); end
        if (h0 !== 4'h0) begin fails++; $display("FAIL %s hits_clear got %0d want 0", tag, h0); end
        if (h9 !== he) begin fails++; $display("FAIL %s hits got %0d want %0d", tag, h9, he); end
        if (h10 !== he) begin fails++; $display("FAIL %s hits_hold got %0d want %0d", tag, h10, he); end
        if (b11 !== hold || d11 !== 1'b0) begin
            fails++;
            $display("FAIL %s restart busy/done got %b%b want %b0", tag, b11, d11, hold);
        end
    endtask

    task automatic test_reset();
        r = 1'b0; start = 1'b0; din = '0; start2 = 1'b0; din2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, hits, x_out, y_mon} !== 8'h00) begin
            fails++;
            $display("FAIL reset busy,done,hits,x,y got %b want 00000000",
                     {busy, done, hits, x_out, y_mon});
        end
        tests++;
        if ({busy2, done2, hits2} !== 4'h0) begin
            fails++;
            $display("FAIL reset_sat got %b want 0000", {busy2, done2, hits2});
        end
    endtask

    task automatic test_patterns();
        logic [7:0] pats [6];
        pats = '{8'h05, 8'h55, 8'hFF, 8'h00, 8'hA0, 8'h01};
        foreach (pats[i]) begin
            launch(pats[i]);
            observe(pats[i], -1, 1'b0, $sformatf("pat_%02h", pats[i]));
        end
    endtask

    task automatic test_ignore_start();
        launch(8'hA0);
        observe(8'hA0, 3, 1'b0, "ignore_start");
    endtask

    task automatic test_back_to_back();
        int got;
        launch(8'h05);
        din = 8'h55;
        observe(8'h05, -1, 1'b1, "b2b_first");
        start = 1'b0;
        got = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin got = k; break; end
        end
        tests += 2;
        if (got != 9) begin fails++; $display("FAIL b2b_latency got %0d want 9", got); end
        if (hits !== 4'(count101(16'h0055, 8))) begin
            fails++;
            $display("FAIL b2b_hits got %0d want %0d", hits, count101(16'h0055, 8));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        int bad;
        launch(8'h55);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL midreset_busy got %b want 1", busy); end
        r = 1'b0;
        #1;
        tests++;
        if ({busy, done, hits, x_out, y_mon} !== 8'h00) begin
            fails++;
            $display("FAIL midreset_clear got %b want 00000000", {busy, done, hits, x_out, y_mon});
        end
        @(negedge clk);
        r = 1'b1;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL midreset_nodone got %0d active cycles want 0", bad); end
        launch(8'h05);
        observe(8'h05, -1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            launch(d);
            observe(d, -1, 1'b0, $sformatf("rand_%02h", d));
        end
    endtask

    task automatic test_saturation();
        logic [15:0] v [6];
        int c, got;
        logic [1:0] he;
        v[0] = 16'h5555; v[1] = 16'h0005;
        for (int i = 2; i < 6; i++) v[i] = 16'($urandom);
        foreach (v[i]) begin
            c  = count101(v[i], 16);
            he = (c > 3) ? 2'd3 : 2'(c);
            @(negedge clk);
            din2 = v[i]; start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            got = -1;
            for (int k = 0; k <= 40; k++) begin
                @(negedge clk);
                if (done2) begin got = k; break; end
            end
            tests += 2;
            if (got != 17) begin fails++; $display("FAIL sat_latency_%04h got %0d want 17", v[i], got); end
            if (hits2 !== he) begin
                fails++;
                $display("FAIL sat_hits_%04h got %0d want %0d", v[i], hits2, he);
            end
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_patterns();
        test_ignore_start();
        test_back_to_back();
        test_reset_midjob();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
